// File: rtl/nav_pkg.sv
// nav_pkg: encodings and limits shared by the navigation FSM and the
// character motion block.
//   nav_state_t : 3-bit navigation command
//                 (STAND/UP/DOWN/LEFT/RIGHT, codes 000..100)
//   vstate_t    : vertical motion state of the character
//                 (GROUNDED/RISING/FALLING)
//   POS_W       : width of every position coordinate
//   SCREEN_*    : default screen limits used as parameter defaults
package nav_pkg;

    localparam int POS_W = 12;

    typedef enum logic [2:0] {
        NAV_STAND = 3'b000,
        NAV_UP    = 3'b001,
        NAV_DOWN  = 3'b010,
        NAV_LEFT  = 3'b011,
        NAV_RIGHT = 3'b100
    } nav_state_t;

    typedef enum logic [1:0] {
        V_GROUNDED = 2'd0,
        V_RISING   = 2'd1,
        V_FALLING  = 2'd2
    } vstate_t;

    localparam logic [POS_W-1:0] SCREEN_X_MIN    = 12'd0;
    localparam logic [POS_W-1:0] SCREEN_X_MAX    = 12'd1000;
    localparam logic [POS_W-1:0] SCREEN_GROUND_Y = 12'd500;

endpackage

// File: rtl/char_motion_clamp.sv
// char_motion_clamp: combinational saturating step on one coordinate.
//   a    : current coordinate
//   step : step magnitude
//   sub  : 1 = move toward lo (a - step), 0 = move toward hi (a + step)
//   lo   : lower clamp (used when sub=1)
//   hi   : upper clamp (used when sub=0)
//   y    : stepped and clamped coordinate
// The comparison is carried out one bit wider than the coordinate so a
// step near either end of the range can never wrap.
module char_motion_clamp #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] step,
    input  logic         sub,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic [W-1:0] y
);

    logic [W:0] sum;

    always_comb begin
        y   = a;
        sum = '0;
        if (sub) begin
            sum = {1'b0, lo} + {1'b0, step};
            if ({1'b0, a} < sum)
                y = lo;
            else
                y = a - step;
        end else begin
            sum = {1'b0, a} + {1'b0, step};
            if (sum > {1'b0, hi})
                y = hi;
            else
                y = sum[W-1:0];
        end
    end

endmodule

// File: rtl/char_motion_ctrl.sv
// char_motion_ctrl: integrates walking, jump rise and gravity fall once per
// frame_tick and produces the character position for the draw stage.
// Coordinates follow VGA convention (y grows downward).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   frame_tick      : one-clk pulse per video frame; all motion happens here
//   nav_state[2:0]  : command from the navigation FSM (see nav_pkg)
//   ground_y_in     : floor y, sampled each tick (only with
//                     CHAR_MOTION_DYN_GROUND_EN defined)
//   xpos, ypos      : registered character position
//   on_the_ground   : registered, 1 when resting on the floor with no jump
//                     pending; fed back to the navigation FSM
// Build option: define CHAR_MOTION_DYN_GROUND_EN to take the floor from
// ground_y_in instead of the fixed GROUND_Y parameter.
module char_motion_ctrl
    import nav_pkg::*;
#(
    parameter logic [11:0] X_INIT      = 12'd100,
    parameter logic [11:0] Y_INIT      = 12'd500,
    parameter logic [11:0] X_MIN       = SCREEN_X_MIN,
    parameter logic [11:0] X_MAX       = SCREEN_X_MAX,
    parameter logic [11:0] GROUND_Y    = SCREEN_GROUND_Y,
    parameter logic [11:0] WALK_STEP   = 12'd4,
    parameter logic [11:0] JUMP_HEIGHT = 12'd120,
    parameter logic [11:0] JUMP_STEP   = 12'd6,
    parameter logic [11:0] MAX_FALL    = 12'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [2:0]  nav_state,
`ifdef CHAR_MOTION_DYN_GROUND_EN
    input  logic [11:0] ground_y_in,
`endif
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        on_the_ground
);

    logic [11:0] ground;
`ifdef CHAR_MOTION_DYN_GROUND_EN
    assign ground = ground_y_in;
`else
    assign ground = GROUND_Y;
`endif

    vstate_t     state, state_n;
    logic        jump_pend, jump_pend_n;
    logic [11:0] rise_cnt, rise_cnt_n;
    logic [11:0] fall_v, fall_v_n, fall_v_inc;
    logic [11:0] xpos_n, ypos_n;
    logic        otg_n;

    logic        walk_l, walk_r, jump_req;
    logic [11:0] x_step, y_step, y_amt;
    logic        y_sub;

    // Illegal codes fall through all three decodes and act as STAND.
    assign walk_l   = (nav_state == NAV_LEFT);
    assign walk_r   = (nav_state == NAV_RIGHT);
    assign jump_req = (nav_state == NAV_UP);

    assign fall_v_inc = (fall_v >= MAX_FALL) ? MAX_FALL : fall_v + 12'd1;

    // Rising (and the first rise step taken from GROUNDED) moves up toward 0;
    // falling moves down and clamps at the floor, so landing is y_step==ground.
    assign y_sub = (state != V_FALLING);
    assign y_amt = y_sub ? JUMP_STEP : fall_v_inc;

    char_motion_clamp #(.W(POS_W)) u_x_clamp (
        .a    (xpos),
        .step (WALK_STEP),
        .sub  (walk_l),
        .lo   (X_MIN),
        .hi   (X_MAX),
        .y    (x_step)
    );

    char_motion_clamp #(.W(POS_W)) u_y_clamp (
        .a    (ypos),
        .step (y_amt),
        .sub  (y_sub),
        .lo   (12'd0),
        .hi   (ground),
        .y    (y_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= V_GROUNDED;
            jump_pend     <= 1'b0;
            rise_cnt      <= '0;
            fall_v        <= '0;
            xpos          <= X_INIT;
            ypos          <= Y_INIT;
            on_the_ground <= 1'b1;
        end else begin
            state         <= state_n;
            jump_pend     <= jump_pend_n;
            rise_cnt      <= rise_cnt_n;
            fall_v        <= fall_v_n;
            xpos          <= xpos_n;
            ypos          <= ypos_n;
            on_the_ground <= otg_n;
        end
    end

    always_comb begin
        state_n     = state;
        jump_pend_n = jump_pend;
        rise_cnt_n  = rise_cnt;
        fall_v_n    = fall_v;
        xpos_n      = xpos;
        ypos_n      = ypos;

        if (frame_tick) begin
            if (walk_l || walk_r)
                xpos_n = x_step;

            case (state)
                V_GROUNDED: begin
                    // A request arriving on the tick itself starts the jump now.
                    if (jump_pend || jump_req) begin
                        jump_pend_n = 1'b0;
                        state_n     = V_RISING;
                        ypos_n      = y_step;
                        rise_cnt_n  = JUMP_STEP;
                        if (JUMP_STEP >= JUMP_HEIGHT || y_step == 12'd0) begin
                            state_n  = V_FALLING;
                            fall_v_n = '0;
                        end
                    end else if (ypos < ground) begin
                        state_n  = V_FALLING;
                        fall_v_n = 12'd1;
                    end
`ifdef CHAR_MOTION_DYN_GROUND_EN
                    else if (ypos > ground) begin
                        ypos_n = ground;
                    end
`endif
                end
                V_RISING: begin
                    ypos_n     = y_step;
                    rise_cnt_n = rise_cnt + JUMP_STEP;
                    if (rise_cnt_n >= JUMP_HEIGHT || y_step == 12'd0) begin
                        state_n  = V_FALLING;
                        fall_v_n = '0;
                    end
                end
                V_FALLING: begin
                    fall_v_n = fall_v_inc;
                    ypos_n   = y_step;
                    if (y_step == ground) begin
                        state_n  = V_GROUNDED;
                        fall_v_n = '0;
                    end
                end
                default: state_n = V_GROUNDED;
            endcase
        end else if (jump_req && state == V_GROUNDED) begin
            jump_pend_n = 1'b1;
        end

        otg_n = (state_n == V_GROUNDED) && !jump_pend_n && (ypos_n == ground);
    end

endmodule

// File: tb/tb_char_motion_ctrl.sv
// tb_char_motion_ctrl: directed vectors for char_motion_ctrl.
// A table of single-cycle vectors covers walking, clamping and illegal
// codes; hand-written sequences cover the jump, fall, landing and reset
// corner cases. A second instance with X_INIT=2 exercises the left clamp.
module tb_char_motion_ctrl;
    import nav_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic [2:0]  nav_state = 3'b000;
    logic [11:0] xpos, ypos, xpos2, ypos2;
    logic        on_the_ground, otg2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    char_motion_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .nav_state     (nav_state),
`ifdef CHAR_MOTION_DYN_GROUND_EN
        .ground_y_in   (12'd500),
`endif
        .xpos          (xpos),
        .ypos          (ypos),
        .on_the_ground (on_the_ground)
    );

    char_motion_ctrl #(.X_INIT(12'd2)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .nav_state     (nav_state),
`ifdef CHAR_MOTION_DYN_GROUND_EN
        .ground_y_in   (12'd500),
`endif
        .xpos          (xpos2),
        .ypos          (ypos2),
        .on_the_ground (otg2)
    );

    typedef struct {
        logic        tick;
        logic [2:0]  nav;
        logic [11:0] ex;
        logic [11:0] ey;
        logic        eotg;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: inputs applied at the falling edge, outputs sampled 1 time
    // unit after the rising edge.
    task automatic cyc(input logic tick, input logic [2:0] nav);
        @(negedge clk);
        frame_tick = tick;
        nav_state  = nav;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        nav_state  = 3'b000;
    endtask

    task automatic chk_pos(input string name, input int ex, input int ey, input int eotg);
        chk({name, ".x"}, xpos, ex);
        chk({name, ".y"}, ypos, ey);
        chk({name, ".otg"}, on_the_ground, eotg);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ey;
        int ex;
        int fall_y [16];

        vecs[0]  = '{1'b1, 3'b100, 12'd104, 12'd500, 1'b1};
        vecs[1]  = '{1'b1, 3'b100, 12'd108, 12'd500, 1'b1};
        vecs[2]  = '{1'b1, 3'b100, 12'd112, 12'd500, 1'b1};
        vecs[3]  = '{1'b1, 3'b100, 12'd116, 12'd500, 1'b1};
        vecs[4]  = '{1'b1, 3'b100, 12'd120, 12'd500, 1'b1};
        vecs[5]  = '{1'b1, 3'b000, 12'd120, 12'd500, 1'b1};
        vecs[6]  = '{1'b0, 3'b100, 12'd120, 12'd500, 1'b1};
        vecs[7]  = '{1'b1, 3'b101, 12'd120, 12'd500, 1'b1};
        vecs[8]  = '{1'b1, 3'b111, 12'd120, 12'd500, 1'b1};
        vecs[9]  = '{1'b1, 3'b010, 12'd120, 12'd500, 1'b1};
        vecs[10] = '{1'b1, 3'b011, 12'd116, 12'd500, 1'b1};

        // Fall from 380 with speed 1,2,..,12,12,...; last entry is the clamp.
        fall_y = '{381, 383, 386, 390, 395, 401, 408, 416,
                   425, 435, 446, 458, 470, 482, 494, 500};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_pos("reset", 100, 500, 1);
        chk("reset.x2", xpos2, 2);
        @(negedge clk);
        rst = 1'b0;

        // Left clamp on the X_INIT=2 instance: no wrap, then hold at 0
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 3'b011);
            chk($sformatf("left_clamp[%0d].x2", i), xpos2, 0);
        end

        // Fresh reset before the table
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_pos("reset2", 100, 500, 1);

        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].tick, vecs[i].nav);
            chk_pos($sformatf("vec[%0d]", i), vecs[i].ex, vecs[i].ey, vecs[i].eotg);
        end

        // Right clamp: 116 + 4*221 = 1000, then hold
        for (int i = 0; i < 225; i++)
            cyc(1'b1, 3'b100);
        chk_pos("right_clamp", 1000, 500, 1);
        cyc(1'b1, 3'b011);
        chk_pos("leave_right", 996, 500, 1);

        // UP pulse without tick: on_the_ground drops, position unchanged
        cyc(1'b0, 3'b001);
        chk_pos("up_pend", 996, 500, 0);
        cyc(1'b0, 3'b000);
        chk_pos("up_pend_hold", 996, 500, 0);

        // 20 rise ticks of 6 pixels each
        ey = 500;
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1, 3'b000);
            ey = ey - 6;
            chk_pos($sformatf("rise[%0d]", k), 996, ey, 0);
        end

        // Fall, with UP commands mixed in that must be ignored
        for (int k = 0; k < 16; k++) begin
            if (k == 2)
                cyc(1'b1, 3'b001);
            else
                cyc(1'b1, 3'b000);
            if (k == 4)
                cyc(1'b0, 3'b001);
            chk_pos($sformatf("fall[%0d]", k), 996, fall_y[k], (k == 15) ? 1 : 0);
        end

        // No re-jump after landing
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 3'b000);
            chk_pos($sformatf("landed[%0d]", k), 996, 500, 1);
        end

        // UP and tick together: jump starts on that tick; walk left meanwhile
        cyc(1'b1, 3'b001);
        chk_pos("up_tick", 996, 494, 0);
        ex = 996;
        ey = 494;
        for (int k = 0; k < 9; k++) begin
            cyc(1'b1, 3'b011);
            ex = ex - 4;
            ey = ey - 6;
            chk_pos($sformatf("rise_walk[%0d]", k), ex, ey, 0);
        end
        chk("mid_rise.y", ypos, 440);

        // Asynchronous reset mid-rise, checked before the next clock edge
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_pos("async_rst", 100, 500, 1);
        @(negedge clk);
        rst = 1'b0;

        // Back in GROUNDED with nothing pending: tick keeps y at the floor
        cyc(1'b1, 3'b100);
        chk_pos("after_rst", 104, 500, 1);
        cyc(1'b1, 3'b000);
        chk_pos("after_rst2", 104, 500, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
